alu_seq: RTL and testbench

//  Multi-cycle command sequencer that drives the combinational alu from the controlling side.

---
 rtl/alu_seq_pkg.sv | 49 ++++
 rtl/alu_seq_ucode.sv | 74 +++++++
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the alu command sequencer.
//   - opcode values OP_PASSA..OP_SHL1
//   - alu control encodings ALUC_*
//   - FSM state, operand-select, carry-in-select and destination encodings
//   - microcode word layout (ucode_t)
// Optional feature macro: ALU_SEQ_XOR_EN (enables the 4-pass XOR opcode).
package alu_seq_pkg;

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADC   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_NEG   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SHL1  = 4'd8;

  localparam logic [3:0] ALUC_A    = 4'b0000;
  localparam logic [3:0] ALUC_B    = 4'b0001;
  localparam logic [3:0] ALUC_NOTA = 4'b0010;
  localparam logic [3:0] ALUC_NOTB = 4'b0011;
  localparam logic [3:0] ALUC_ADD  = 4'b0100;
  localparam logic [3:0] ALUC_ADC  = 4'b0101;
  localparam logic [3:0] ALUC_OR   = 4'b0110;
  localparam logic [3:0] ALUC_AND  = 4'b0111;
  localparam logic [3:0] ALUC_ZERO = 4'b1000;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
  typedef enum logic [2:0] {SEL_ZERO, SEL_A, SEL_B, SEL_TMP0, SEL_TMP1} sel_t;
  typedef enum logic [1:0] {CIN_0, CIN_1, CIN_CQ} cin_t;
  typedef enum logic [1:0] {DEST_TMP0, DEST_TMP1, DEST_RES} dest_t;

  typedef struct packed {
    logic [3:0] aluc;
    sel_t       sel_a;
    sel_t       sel_b;
    cin_t       cin_sel;
    dest_t      dest;
    logic       last;
    logic       legal;
  } ucode_t;

  // Only adder passes produce meaningful carry/overflow flags.
  function automatic logic is_arith(input logic [3:0] aluc);
    return (aluc == ALUC_ADD) || (aluc == ALUC_ADC);
  endfunction

endpackage

// File: rtl/alu_seq_ucode.sv
// alu_seq_ucode: combinational microcode ROM for the alu sequencer.
//   op    in  OP_W  latched opcode
//   step  in  2     pass index within the operation
//   uc    out       {aluc, sel_a, sel_b, cin_sel, dest, last, legal}
// Optional feature macro: ALU_SEQ_XOR_EN (adds the 4-pass XOR sequence).
module alu_seq_ucode
  import alu_seq_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      step,
  output ucode_t          uc
);

  always_comb begin
    uc         = '0;
    uc.aluc    = ALUC_ZERO;
    uc.sel_a   = SEL_ZERO;
    uc.sel_b   = SEL_ZERO;
    uc.cin_sel = CIN_0;
    uc.dest    = DEST_RES;
    uc.last    = 1'b1;
    uc.legal   = 1'b1;
    case (op)
      OP_W'(OP_PASSA): begin uc.aluc = ALUC_A;   uc.sel_a = SEL_A; end
      OP_W'(OP_ADD):   begin uc.aluc = ALUC_ADD; uc.sel_a = SEL_A; uc.sel_b = SEL_B; end
      OP_W'(OP_ADC): begin
        uc.aluc = ALUC_ADC; uc.sel_a = SEL_A; uc.sel_b = SEL_B; uc.cin_sel = CIN_CQ;
      end
      // A - B computed as A + ~B + 1 so the alu carry is the usual no-borrow flag.
      OP_W'(OP_SUB): begin
        if (step == 2'd0) begin
          uc.aluc = ALUC_NOTB; uc.sel_b = SEL_B; uc.dest = DEST_TMP0; uc.last = 1'b0;
        end else begin
          uc.aluc = ALUC_ADC; uc.sel_a = SEL_A; uc.sel_b = SEL_TMP0; uc.cin_sel = CIN_1;
        end
      end
      OP_W'(OP_NEG): begin
        if (step == 2'd0) begin
          uc.aluc = ALUC_NOTA; uc.sel_a = SEL_A; uc.dest = DEST_TMP0; uc.last = 1'b0;
        end else begin
          uc.aluc = ALUC_ADC; uc.sel_a = SEL_TMP0; uc.sel_b = SEL_ZERO; uc.cin_sel = CIN_1;
        end
      end
      OP_W'(OP_OR):   begin uc.aluc = ALUC_OR;  uc.sel_a = SEL_A; uc.sel_b = SEL_B; end
      OP_W'(OP_AND):  begin uc.aluc = ALUC_AND; uc.sel_a = SEL_A; uc.sel_b = SEL_B; end
      OP_W'(OP_SHL1): begin uc.aluc = ALUC_ADD; uc.sel_a = SEL_A; uc.sel_b = SEL_A; end
`ifdef ALU_SEQ_XOR_EN
      // A ^ B = (A | B) & ~(A & B); the alu has no XOR control.
      OP_W'(OP_XOR): begin
        case (step)
          2'd0: begin
            uc.aluc = ALUC_OR; uc.sel_a = SEL_A; uc.sel_b = SEL_B;
            uc.dest = DEST_TMP0; uc.last = 1'b0;
          end
          2'd1: begin
            uc.aluc = ALUC_AND; uc.sel_a = SEL_A; uc.sel_b = SEL_B;
            uc.dest = DEST_TMP1; uc.last = 1'b0;
          end
          2'd2: begin
            uc.aluc = ALUC_NOTA; uc.sel_a = SEL_TMP1; uc.dest = DEST_TMP1; uc.last = 1'b0;
          end
          default: begin
            uc.aluc = ALUC_AND; uc.sel_a = SEL_TMP0; uc.sel_b = SEL_TMP1;
          end
        endcase
      end
`endif
      default: uc.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle command sequencer driving a combinational alu.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b  command port (accepted in IDLE)
//   rsp_valid/rsp_ready/rsp_data/rsp_cout/rsp_ovf/rsp_err  response port
//   alu_ina/alu_inb/alu_aluc/alu_cin  alu drive, from registered state
//   alu_out/alu_cout/alu_overflow     alu results, captured each pass
// Optional feature macro: ALU_SEQ_XOR_EN (4-pass XOR opcode and tmp1 register).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_ina,
  output logic [WIDTH-1:0] alu_inb,
  output logic [3:0]       alu_aluc,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_overflow
);

  state_t           state_reg, state_next;
  logic [1:0]       step_reg, step_next;
  logic [OP_W-1:0]  op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
  logic [WIDTH-1:0] tmp0_reg, tmp0_next;
  logic [WIDTH-1:0] tmp1_val;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             cout_reg, cout_next, ovf_reg, ovf_next, err_reg, err_next;
  ucode_t           uc;

`ifdef ALU_SEQ_XOR_EN
  logic [WIDTH-1:0] tmp1_reg, tmp1_next;
  assign tmp1_val = tmp1_reg;
`else
  assign tmp1_val = '0;
`endif

  alu_seq_ucode #(.OP_W(OP_W)) u_ucode (
    .op   (op_reg),
    .step (step_reg),
    .uc   (uc)
  );

  function automatic logic [WIDTH-1:0] pick(input sel_t s, input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] t0, input logic [WIDTH-1:0] t1);
    case (s)
      SEL_A:    return a;
      SEL_B:    return b;
      SEL_TMP0: return t0;
      SEL_TMP1: return t1;
      default:  return '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      tmp0_reg  <= '0;
`ifdef ALU_SEQ_XOR_EN
      tmp1_reg  <= '0;
`endif
      carry_reg <= 1'b0;
      data_reg  <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      tmp0_reg  <= tmp0_next;
`ifdef ALU_SEQ_XOR_EN
      tmp1_reg  <= tmp1_next;
`endif
      carry_reg <= carry_next;
      data_reg  <= data_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    tmp0_next  = tmp0_reg;
`ifdef ALU_SEQ_XOR_EN
    tmp1_next  = tmp1_reg;
`endif
    carry_next = carry_reg;
    data_next  = data_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    err_next   = err_reg;
    alu_ina    = '0;
    alu_inb    = '0;
    alu_aluc   = ALUC_ZERO;
    alu_cin    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_next    = cmd_op;
          a_next     = cmd_a;
          b_next     = cmd_b;
          step_next  = '0;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!uc.legal) begin
          // Illegal opcode: the alu stays idle and carry is left alone.
          data_next  = '0;
          cout_next  = 1'b0;
          ovf_next   = 1'b0;
          err_next   = 1'b1;
          state_next = ST_RESP;
        end else begin
          alu_aluc = uc.aluc;
          alu_ina  = pick(uc.sel_a, a_reg, b_reg, tmp0_reg, tmp1_val);
          alu_inb  = pick(uc.sel_b, a_reg, b_reg, tmp0_reg, tmp1_val);
          case (uc.cin_sel)
            CIN_1:   alu_cin = 1'b1;
            CIN_CQ:  alu_cin = carry_reg;
            default: alu_cin = 1'b0;
          endcase
          case (uc.dest)
            DEST_TMP0: tmp0_next = alu_out;
`ifdef ALU_SEQ_XOR_EN
            DEST_TMP1: tmp1_next = alu_out;
`endif
            default:   data_next = alu_out;
          endcase
          if (uc.last) begin
            // Flags are only meaningful from an adder pass; logic results report 0.
            cout_next = is_arith(uc.aluc) & alu_cout;
            ovf_next  = is_arith(uc.aluc) & alu_overflow;
            err_next  = 1'b0;
            if (is_arith(uc.aluc)) carry_next = alu_cout;
            state_next = ST_RESP;
          end else begin
            step_next = step_reg + 2'd1;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_data  = data_reg;
  assign rsp_cout  = cout_reg;
  assign rsp_ovf   = ovf_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a behavioural alu and a
// scoreboard of expected responses built from a reference model.
// Optional feature macro: ALU_SEQ_XOR_EN (XOR expectations).
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b, rsp_data;
  logic        rsp_cout, rsp_ovf, rsp_err;
  logic [31:0] alu_ina, alu_inb, alu_out;
  logic [3:0]  alu_aluc;
  logic        alu_cin, alu_cout, alu_overflow;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_aluc(alu_aluc), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_overflow(alu_overflow)
  );

  // Behavioural combinational alu.
  logic [32:0] alu_sum;
  always_comb begin
    alu_out      = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    alu_sum      = '0;
    case (alu_aluc)
      4'b0000: alu_out = alu_ina;
      4'b0001: alu_out = alu_inb;
      4'b0010: alu_out = ~alu_ina;
      4'b0011: alu_out = ~alu_inb;
      4'b0100, 4'b0101: begin
        alu_sum = {1'b0, alu_ina} + {1'b0, alu_inb}
                + {32'd0, (alu_aluc == 4'b0101) ? alu_cin : 1'b0};
        alu_out      = alu_sum[31:0];
        alu_cout     = alu_sum[32];
        alu_overflow = (alu_ina[31] == alu_inb[31]) && (alu_out[31] != alu_ina[31]);
      end
      4'b0110: alu_out = alu_ina | alu_inb;
      4'b0111: alu_out = alu_ina & alu_inb;
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic [31:0] data;
    logic        cout;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic model_cq = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: direct arithmetic on the operands.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    e.data = '0; e.cout = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 1;
    case (op)
      4'd0: e.data = a;
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        e.data = s[31:0]; e.cout = s[32];
        e.ovf = (a[31] == b[31]) && (e.data[31] != a[31]);
        model_cq = e.cout;
      end
      4'd2: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, model_cq};
        e.data = s[31:0]; e.cout = s[32];
        e.ovf = (a[31] == b[31]) && (e.data[31] != a[31]);
        model_cq = e.cout;
      end
      4'd3: begin
        e.data = a - b; e.cout = (a >= b);
        e.ovf = (a[31] != b[31]) && (e.data[31] != a[31]);
        e.lat = 2; model_cq = e.cout;
      end
      4'd4: begin
        e.data = 32'd0 - a; e.cout = (a == 32'd0);
        e.ovf = (a == 32'h8000_0000);
        e.lat = 2; model_cq = e.cout;
      end
      4'd5: e.data = a | b;
      4'd6: e.data = a & b;
`ifdef ALU_SEQ_XOR_EN
      4'd7: begin e.data = a ^ b; e.lat = 4; end
`endif
      4'd8: begin
        e.data = a << 1; e.cout = a[31]; e.ovf = a[31] ^ a[30];
        model_cq = e.cout;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int hold);
    exp_t e;
    int   lat;
    int   guard;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    check("cmd_ready_before_accept", {63'd0, cmd_ready}, 64'd1);
    sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!rsp_valid && lat < 10);
    check("rsp_valid_timeout", {63'd0, rsp_valid}, 64'd1);
    e = sb.pop_front();
    check("latency", 64'(lat), 64'(e.lat));
    check("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
    check("rsp_cout", {63'd0, rsp_cout}, {63'd0, e.cout});
    check("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
    check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
    check("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_data", {32'd0, rsp_data}, {32'd0, e.data});
      check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rsp", {63'd0, cmd_ready}, 64'd1);
    check("rsp_valid_after_rsp", {63'd0, rsp_valid}, 64'd0);
    $display("txn op=%0d a=%h b=%h data=%h cout=%0b ovf=%0b err=%0b lat=%0d",
             op, a, b, rsp_data, rsp_cout, rsp_ovf, rsp_err, lat);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check({tag, "_rsp_data"}, {32'd0, rsp_data}, 64'd0);
    check({tag, "_rsp_flags"}, {61'd0, rsp_cout, rsp_ovf, rsp_err}, 64'd0);
    check({tag, "_aluc"}, {60'd0, alu_aluc}, 64'h8);
    check({tag, "_ina_inb_cin"}, {alu_ina, alu_inb[30:0], alu_cin}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    send(4'd1, 32'hFFFF_FFFF, 32'h1, 0);          // ADD wrap, carry out
    send(4'd3, 32'd5, 32'd7, 0);                   // SUB negative result
    send(4'd1, 32'hFFFF_FFFF, 32'h1, 0);          // set carry_q
    send(4'hF, 32'h1234, 32'h5678, 0);             // illegal, carry_q kept
    send(4'd2, 32'd2, 32'd3, 0);                   // ADC uses carry_q=1 -> 6
    send(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);   // XOR or illegal
    send(4'd4, 32'h8000_0000, 32'd0, 0);           // NEG overflow
    send(4'd4, 32'd0, 32'd0, 0);                   // NEG zero, carry out
    send(4'd5, 32'hA5A5_0000, 32'h0000_5A5A, 0);   // OR
    send(4'd6, 32'hFFFF_0F0F, 32'h0F0F_FFFF, 0);   // AND
    send(4'd0, 32'hDEAD_BEEF, 32'h0, 0);           // PASSA
    send(4'd8, 32'h4000_0001, 32'd0, 0);           // SHL1 overflow
    send(4'd3, 32'h8000_0000, 32'd1, 0);           // SUB signed overflow
    send(4'd9, 32'd1, 32'd1, 0);                   // lowest illegal opcode
    send(4'd1, 32'h7FFF_FFFF, 32'd1, 5);           // held response

    // Reset pulsed mid-operation: no response and everything back to idle.
    @(negedge clk);
    cmd_valid = 1'b1;
`ifdef ALU_SEQ_XOR_EN
    cmd_op = 4'd7;
`else
    cmd_op = 4'd3;
`endif
    cmd_a = 32'h1111_1111; cmd_b = 32'h2222_2222;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
`ifdef ALU_SEQ_XOR_EN
    repeat (2) @(posedge clk);
`else
    repeat (1) @(posedge clk);
`endif
    #1 rst_n = 1'b0;
    #2 check_idle_outputs("abort");
    model_cq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    send(4'd1, 32'd1, 32'd1, 0);                   // ADD after abort
    send(4'd2, 32'd0, 32'd0, 0);                   // ADC: carry_q cleared by reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
